// File: rtl/dmem_arbiter_if.sv
// Data memory arbiter bundle: CPU port, EXT port and memory side.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ready, ext_rdata, ext_ack,
        output mem_re, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ready, ext_rdata, ext_ack,
        input  mem_re, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares data memory between the MEM stage (CPU) and an EXT loader port.
// Ports: clk, rst (sync, active-high), bus (dmem_arbiter_if.slave).
// Option: DMEM_ARB_STARVE_EN bounds consecutive CPU wins while EXT waits.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        EXT_ACC,
        DONE
    } state_t;

    localparam logic [3:0] LAST     = 4'(MEM_LAT - 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_EXT  = 2'b10;

    if (MEM_LAT < 1 || MEM_LAT > 15 ||
        STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
        $error("dmem_arbiter: MEM_LAT/STARVE_MAX outside 1..15");
    end

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        owner_q, owner_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              ext_ack_q, ext_ack_d;
    logic              grant_cpu, grant_ext;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_NONE;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            ext_ack_q   <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            ext_ack_q   <= ext_ack_d;
`ifdef DMEM_ARB_STARVE_EN
            starve_q    <= starve_d;
`endif
        end
    end

    // The mem_* registers double as the latched copy of the winner's
    // request, so mid-access payload changes never reach memory.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        ext_ack_d   = 1'b0;
        grant_cpu   = 1'b0;
        grant_ext   = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
        starve_d    = starve_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DMEM_ARB_STARVE_EN
                grant_cpu = bus.cpu_req &&
                            !(bus.ext_req && starve_q == SMAX);
`else
                grant_cpu = bus.cpu_req;
`endif
                grant_ext = bus.ext_req && !grant_cpu;
                cnt_d     = '0;
                if (grant_cpu) begin
                    state_d     = CPU_ACC;
                    owner_d     = OWN_CPU;
                    mem_re_d    = !bus.cpu_we;
                    mem_we_d    = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                end else if (grant_ext) begin
                    state_d     = EXT_ACC;
                    owner_d     = OWN_EXT;
                    mem_re_d    = !bus.ext_we;
                    mem_we_d    = bus.ext_we;
                    mem_addr_d  = bus.ext_addr;
                    mem_wdata_d = bus.ext_wdata;
                end
`ifdef DMEM_ARB_STARVE_EN
                if (!bus.ext_req || grant_ext) begin
                    starve_d = '0;
                end else if (grant_cpu && starve_q != SMAX) begin
                    starve_d = starve_q + 4'd1;
                end
`endif
            end
            CPU_ACC, EXT_ACC: begin
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == CPU_ACC) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end else begin
                        ext_rdata_d = bus.mem_rdata;
                        ext_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_ready = !bus.cpu_req ||
                           (state_q == DONE && owner_q == OWN_CPU);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ext_rdata = ext_rdata_q;
    assign bus.ext_ack   = ext_ack_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard testbench for dmem_arbiter with a word-addressed memory model.
// Covers reset, CPU read, EXT write/read, collision, starvation, reset abort.
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 2;

    typedef struct {
        logic          is_ext;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    exp_t          sb[$];
    logic [1:0]    grant_log[$];
    logic [1:0]    prev_owner = 2'b00;
    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MEM_LAT(LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4] <= 32'hDEADBEEF;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus.owner != 2'b00 && prev_owner == 2'b00)
            grant_log.push_back(bus.owner);
        prev_owner <= bus.owner;
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 0; bus.ext_we = 0;
        bus.ext_addr = '0; bus.ext_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.owner, bus.mem_re, bus.mem_we, bus.ext_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b want 00000",
                {bus.owner, bus.mem_re, bus.mem_we, bus.ext_ack});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_mem: got addr=%h wdata=%h want 0",
                bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.cpu_rdata !== '0 || bus.ext_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got cpu=%h ext=%h want 0",
                bus.cpu_rdata, bus.ext_rdata);
        end
        checks++;
        if (bus.cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", bus.cpu_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        int   n_ready = 0;
        int   n_re    = 0;
        int   n_low   = 0;
        bit   done    = 0;
        exp_t e;
        bus.cpu_req = 1; bus.cpu_we = 0;
        bus.cpu_addr = 32'h10; bus.cpu_wdata = '0;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            if (bus.mem_re) n_re++;
            if (bus.cpu_ready) begin
                done = 1; n_ready = n;
                e = sb.pop_front();
                checks++;
                if (bus.cpu_rdata !== e.data) begin
                    failures++;
                    $display("FAIL cpu_rdata: got %h want %h",
                        bus.cpu_rdata, e.data);
                end
                bus.cpu_req = 0;
            end else begin
                n_low++;
            end
        end
        checks++;
        if (!done) begin
            failures++; sb.delete();
            $display("FAIL cpu_read_timeout: got no ready want ready");
        end
        checks++;
        if (n_ready != LAT + 1) begin
            failures++;
            $display("FAIL cpu_latency: got %0d want %0d", n_ready, LAT + 1);
        end
        checks++;
        if (n_re != LAT) begin
            failures++;
            $display("FAIL cpu_mem_re: got %0d want %0d", n_re, LAT);
        end
        checks++;
        if (n_low != LAT) begin
            failures++;
            $display("FAIL cpu_stall: got %0d want %0d", n_low, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_ext();
        int   n_we = 0, n_ok = 0, n_ack = 0, ack_n = 0, rdy_bad = 0;
        bit   done = 0;
        exp_t e;
        bus.ext_req = 1; bus.ext_we = 1;
        bus.ext_addr = 32'h20; bus.ext_wdata = 32'h1234;
        for (int n = 1; n <= LAT + 6; n++) begin
            @(negedge clk);
            if (bus.mem_we) n_we++;
            if (bus.mem_we && bus.mem_addr === 32'h20 &&
                bus.mem_wdata === 32'h1234) n_ok++;
            if (bus.cpu_ready !== 1'b1) rdy_bad++;
            if (bus.ext_ack) begin
                n_ack++; ack_n = n; bus.ext_req = 0;
            end
        end
        checks++;
        if (n_we != LAT || n_ok != LAT) begin
            failures++;
            $display("FAIL ext_wr_cycles: got we=%0d ok=%0d want %0d",
                n_we, n_ok, LAT);
        end
        checks++;
        if (n_ack != 1 || ack_n != LAT + 1) begin
            failures++;
            $display("FAIL ext_ack: got n=%0d at=%0d want 1 at %0d",
                n_ack, ack_n, LAT + 1);
        end
        checks++;
        if (rdy_bad != 0) begin
            failures++;
            $display("FAIL ext_cpu_ready: got %0d low want 0", rdy_bad);
        end
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_wdata = '0;
        sb.push_back('{1'b1, 32'h1234});
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            if (bus.ext_ack) begin
                done = 1;
                e = sb.pop_front();
                checks++;
                if (bus.ext_rdata !== e.data) begin
                    failures++;
                    $display("FAIL ext_rdata: got %h want %h",
                        bus.ext_rdata, e.data);
                end
                bus.ext_req = 0;
            end
        end
        checks++;
        if (!done) begin
            failures++; sb.delete();
            $display("FAIL ext_read_timeout: got no ack want ack");
        end
        checks++;
        if (bus.cpu_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL cpu_rdata_kept: got %h want deadbeef",
                bus.cpu_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_collision();
        int   base = grant_log.size();
        int   cpu_n = -1, ext_g = -1;
        exp_t e;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h20;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b1, 32'h1234});
        for (int n = 1; n <= 40 && (bus.cpu_req || bus.ext_req); n++) begin
            @(negedge clk);
            if (bus.owner == 2'b10 && ext_g < 0) ext_g = n;
            if (bus.cpu_req && bus.cpu_ready && bus.owner == 2'b01) begin
                cpu_n = n; bus.cpu_req = 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL coll_cpu: got completion want none");
                end else begin
                    e = sb.pop_front();
                    if (e.is_ext !== 1'b0 || bus.cpu_rdata !== e.data) begin
                        failures++;
                        $display("FAIL coll_cpu: got cpu %h want ext=%b %h",
                            bus.cpu_rdata, e.is_ext, e.data);
                    end
                end
            end
            if (bus.ext_ack) begin
                bus.ext_req = 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL coll_ext: got ack want none");
                end else begin
                    e = sb.pop_front();
                    if (e.is_ext !== 1'b1 || bus.ext_rdata !== e.data) begin
                        failures++;
                        $display("FAIL coll_ext: got ext %h want ext=%b %h",
                            bus.ext_rdata, e.is_ext, e.data);
                    end
                end
            end
        end
        checks++;
        if (bus.cpu_req || bus.ext_req || sb.size() != 0) begin
            failures++; sb.delete();
            $display("FAIL coll_timeout: got pending want done");
            bus.cpu_req = 0; bus.ext_req = 0;
        end
        checks++;
        if (grant_log.size() < base + 2) begin
            failures++;
            $display("FAIL coll_order: got %0d grants want 2",
                grant_log.size() - base);
        end else if (grant_log[base] !== 2'b01 ||
                     grant_log[base+1] !== 2'b10) begin
            failures++;
            $display("FAIL coll_order: got %b,%b want 01,10",
                grant_log[base], grant_log[base+1]);
        end
        checks++;
        if (ext_g != cpu_n + 2) begin
            failures++;
            $display("FAIL coll_ext_grant: got %0d want %0d",
                ext_g, cpu_n + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int         base = grant_log.size();
        bit         stop = 0;
        int         ack_early = 0;
        int         ack_want;
        logic [1:0] pat [6];
`ifdef DMEM_ARB_STARVE_EN
        pat = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        ack_want = 1;
`else
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        ack_want = 0;
`endif
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h20;
        for (int n = 1; n <= 200 && (bus.cpu_req || bus.ext_req); n++) begin
            @(negedge clk);
            if (!stop && grant_log.size() >= base + 6) stop = 1;
            if (bus.cpu_req && bus.cpu_ready && bus.owner == 2'b01) begin
                checks++;
                if (bus.cpu_rdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL starve_cpu_rdata: got %h want deadbeef",
                        bus.cpu_rdata);
                end
                if (stop) bus.cpu_req = 0;
            end
            if (bus.ext_ack) begin
                if (!stop) ack_early++;
                if (stop && !bus.cpu_req) bus.ext_req = 0;
            end
        end
        checks++;
        if (bus.cpu_req || bus.ext_req) begin
            failures++;
            $display("FAIL starve_timeout: got pending want done");
            bus.cpu_req = 0; bus.ext_req = 0;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (grant_log.size() <= base + i) begin
                failures++;
                $display("FAIL starve_grant%0d: got none want %b", i, pat[i]);
            end else if (grant_log[base+i] !== pat[i]) begin
                failures++;
                $display("FAIL starve_grant%0d: got %b want %b",
                    i, grant_log[base+i], pat[i]);
            end
        end
        checks++;
        if (ack_early != ack_want) begin
            failures++;
            $display("FAIL starve_ext_acks: got %0d want %0d",
                ack_early, ack_want);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hCAFE0001;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.owner !== 2'b01) begin
            failures++;
            $display("FAIL mid_acc: got we=%b owner=%b want 1 01",
                bus.mem_we, bus.owner);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.owner !== 2'b00 ||
            bus.ext_ack !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort: got we=%b owner=%b ack=%b want 0 00 0",
                bus.mem_we, bus.owner, bus.ext_ack);
        end
        checks++;
        if (bus.cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready: got %b want 0", bus.cpu_ready);
        end
        rst = 1'b0;
        bus.cpu_req = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (bus.owner !== 2'b00 || bus.mem_we !== 1'b0 ||
                bus.mem_re !== 1'b0 || bus.ext_ack !== 1'b0 ||
                bus.cpu_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_no_done: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ext();
        test_collision();
        test_starvation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
